avr_bus_master: RTL and testbench

- Synthesizable AVR-side initiator for the CPLD host bus.
- Turns single-cycle commands into pin sequences for the CPLD:
  - serial address shift into the address shift register (avr_si / avr_sreg_en_n);
  - SRAM read (avr_oe_n) and SRAM write (avr_we_n);
  - address increment pulse (avr_counter_n).
- Used in an FPGA-hosted AVR replacement and as a drop-in stimulus engine for system-level benches.

---
 rtl/avr_bus_pkg.sv | 33 +++
 rtl/avr_sreg_tx.sv | 71 +++++++
 rtl/avr_bus_master.sv | 169 ++++++++++++++++
 tb/tb_avr_bus_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_bus_pkg.sv
// Shared op codes, FSM state encoding and default timing for the AVR-side bus initiator.
package avr_bus_pkg;

  localparam logic [1:0] OP_LOAD_ADDR = 2'd0;
  localparam logic [1:0] OP_READ      = 2'd1;
  localparam logic [1:0] OP_WRITE     = 2'd2;
  localparam logic [1:0] OP_INC       = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_SHIFT       = 4'd1,
    ST_SHIFT_TAIL  = 4'd2,
    ST_READ        = 4'd3,
    ST_WRITE_SETUP = 4'd4,
    ST_WRITE       = 4'd5,
    ST_WRITE_HOLD  = 4'd6,
    ST_INC_LO      = 4'd7,
    ST_INC_HI      = 4'd8
  } state_t;

  localparam int DEF_ADDR_WIDTH = 21;
  localparam int DEF_BIT_CYCLES = 2;
  localparam int DEF_RD_CYCLES  = 4;
  localparam int DEF_WR_CYCLES  = 4;
  localparam int DEF_CNT_CYCLES = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/avr_sreg_tx.sv
// MSB-first address serializer: holds each bit BIT_CYCLES clocks, then one tail clock with si=0.
module avr_sreg_tx
  import avr_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_bit,
  output logic                  done,
  output logic                  si,
  output logic                  sreg_en_n
);

  localparam int BW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_FIRST = BW'(ADDR_WIDTH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);

  logic [ADDR_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_idx;
  logic [HW-1:0]         hold_cnt;
  logic                  shifting;
  logic                  tail;

  // last_bit flags the final hold clock of bit 0 so the FSM can enter its tail state in step
  assign last_bit = shifting && (bit_idx == '0) && (hold_cnt == HOLD_LAST);
  assign done     = tail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_idx   <= '0;
      hold_cnt  <= '0;
      shifting  <= 1'b0;
      tail      <= 1'b0;
      si        <= 1'b0;
      sreg_en_n <= 1'b1;
    end else if (start) begin
      shreg     <= addr;
      si        <= addr[ADDR_WIDTH-1];
      sreg_en_n <= 1'b0;
      shifting  <= 1'b1;
      tail      <= 1'b0;
      bit_idx   <= BIT_FIRST;
      hold_cnt  <= '0;
    end else if (shifting) begin
      if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= '0;
        if (bit_idx == '0) begin
          shifting <= 1'b0;
          tail     <= 1'b1;
          si       <= 1'b0;
        end else begin
          bit_idx <= bit_idx - 1'b1;
          shreg   <= shreg << 1;
          si      <= shreg[ADDR_WIDTH-2];
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end else if (tail) begin
      tail      <= 1'b0;
      sreg_en_n <= 1'b1;
    end
  end

endmodule

// File: rtl/avr_bus_master.sv
// AVR-side CPLD bus initiator: turns single-cycle commands into registered pin sequences.
module avr_bus_master
  import avr_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int RD_CYCLES  = DEF_RD_CYCLES,
  parameter int WR_CYCLES  = DEF_WR_CYCLES,
  parameter int CNT_CYCLES = DEF_CNT_CYCLES
) (
  input  logic                  avr_clk,
  input  logic                  avr_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  busy,
  output logic                  avr_si,
  output logic                  avr_sreg_en_n,
  output logic                  avr_oe_n,
  output logic                  avr_we_n,
  output logic                  avr_counter_n,
  output logic [7:0]            avr_data_out,
  output logic                  avr_data_oe,
  input  logic [7:0]            avr_data_in
);

  localparam int CW = $clog2(max3(RD_CYCLES, WR_CYCLES, CNT_CYCLES) + 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          oe_n_nxt, we_n_nxt, counter_n_nxt, data_oe_nxt, rsp_valid_nxt;
  logic [7:0]    data_out_nxt, rdata_nxt;
  logic          tx_start, tx_last, tx_done;
  logic          accept;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;

  avr_sreg_tx #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BIT_CYCLES(BIT_CYCLES)
  ) u_sreg_tx (
    .clk      (avr_clk),
    .rst_n    (avr_reset_n),
    .start    (tx_start),
    .addr     (cmd_addr),
    .last_bit (tx_last),
    .done     (tx_done),
    .si       (avr_si),
    .sreg_en_n(avr_sreg_en_n)
  );

  // Next values of every registered pin; each state owns exactly one strobe so they never overlap
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    oe_n_nxt      = avr_oe_n;
    we_n_nxt      = avr_we_n;
    counter_n_nxt = avr_counter_n;
    data_oe_nxt   = avr_data_oe;
    data_out_nxt  = avr_data_out;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rsp_rdata;
    tx_start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD_ADDR: begin
              tx_start  = 1'b1;
              state_nxt = ST_SHIFT;
            end
            OP_READ: begin
              oe_n_nxt  = 1'b0;
              cnt_nxt   = '0;
              state_nxt = ST_READ;
            end
            OP_WRITE: begin
              data_out_nxt = cmd_wdata;
              data_oe_nxt  = 1'b1;
              state_nxt    = ST_WRITE_SETUP;
            end
            default: begin
              counter_n_nxt = 1'b0;
              cnt_nxt       = '0;
              state_nxt     = ST_INC_LO;
            end
          endcase
        end
      end
      ST_SHIFT:      if (tx_last) state_nxt = ST_SHIFT_TAIL;
      ST_SHIFT_TAIL: if (tx_done) state_nxt = ST_IDLE;
      ST_READ: begin
        if (cnt == RD_LAST) begin
          oe_n_nxt      = 1'b1;
          rsp_valid_nxt = 1'b1;
          rdata_nxt     = avr_data_in;
          state_nxt     = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WRITE_SETUP: begin
        we_n_nxt  = 1'b0;
        cnt_nxt   = '0;
        state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (cnt == WR_LAST) begin
          we_n_nxt  = 1'b1;
          state_nxt = ST_WRITE_HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WRITE_HOLD: begin
        data_oe_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
      ST_INC_LO: begin
        if (cnt == CNT_LAST) begin
          counter_n_nxt = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = ST_INC_HI;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_INC_HI: begin
        if (cnt == CNT_LAST) state_nxt = ST_IDLE;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge avr_clk) begin
    if (!avr_reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      avr_oe_n      <= 1'b1;
      avr_we_n      <= 1'b1;
      avr_counter_n <= 1'b1;
      avr_data_oe   <= 1'b0;
      avr_data_out  <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      avr_oe_n      <= oe_n_nxt;
      avr_we_n      <= we_n_nxt;
      avr_counter_n <= counter_n_nxt;
      avr_data_oe   <= data_oe_nxt;
      avr_data_out  <= data_out_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_rdata     <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_avr_bus_master.sv
// Directed bench for avr_bus_master with ADDR_WIDTH=15 and default timing.
module tb_avr_bus_master;
  import avr_bus_pkg::*;

  localparam int AW = 15;

  logic          avr_clk = 1'b0;
  logic          avr_reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_wdata;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          busy;
  logic          avr_si, avr_sreg_en_n, avr_oe_n, avr_we_n, avr_counter_n;
  logic [7:0]    avr_data_out;
  logic          avr_data_oe;
  logic [7:0]    avr_data_in;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;

  logic inc_mon = 1'b0;
  int   lo_run, hi_run, pulses, min_gap;
  int   pulse_len [4];

  always #5 avr_clk = ~avr_clk;

  avr_bus_master #(
    .ADDR_WIDTH(AW), .BIT_CYCLES(2), .RD_CYCLES(4), .WR_CYCLES(4), .CNT_CYCLES(2)
  ) dut (
    .avr_clk      (avr_clk),
    .avr_reset_n  (avr_reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .avr_si       (avr_si),
    .avr_sreg_en_n(avr_sreg_en_n),
    .avr_oe_n     (avr_oe_n),
    .avr_we_n     (avr_we_n),
    .avr_counter_n(avr_counter_n),
    .avr_data_out (avr_data_out),
    .avr_data_oe  (avr_data_oe),
    .avr_data_in  (avr_data_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge avr_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [7:0] wd);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Strobe exclusivity and bus-direction invariants, sampled mid-cycle
  always @(negedge avr_clk) begin
    if (avr_reset_n) begin
      if ((int'(!avr_sreg_en_n) + int'(!avr_oe_n) + int'(!avr_we_n) + int'(!avr_counter_n)) > 1)
        viol++;
      if (!avr_oe_n && avr_data_oe) viol++;
    end
    if (inc_mon) begin
      if (!avr_counter_n) begin
        if (lo_run == 0 && pulses > 0 && hi_run < min_gap) min_gap = hi_run;
        lo_run++;
        hi_run = 0;
      end else begin
        if (lo_run > 0) begin
          if (pulses < 4) pulse_len[pulses] = lo_run;
          pulses++;
          lo_run = 0;
        end
        hi_run++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          samp [64];
    logic [AW-1:0] model;
    logic [7:0]    rd_vals [2];
    int            exp_seq [15];
    int            n, bad;
    logic          exp_we, exp_oe;

    exp_seq = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1};
    rd_vals = '{8'haa, 8'hbb};

    avr_reset_n = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = OP_LOAD_ADDR;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    avr_data_in = '0;
    repeat (3) tick();

    check("rst_pins", 32'({avr_si, avr_sreg_en_n, avr_oe_n, avr_we_n, avr_counter_n, avr_data_oe}),
          32'(6'b011110));
    check("rst_data", 32'({avr_data_out, rsp_rdata}), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_ready_busy", 32'({cmd_ready, busy}), 32'(2'b10));
    avr_reset_n = 1'b1;
    tick();

    // LOAD_ADDR 0x4ccf
    issue(OP_LOAD_ADDR, 15'h4ccf, 8'h00);
    n = 0;
    while (!avr_sreg_en_n && n < 64) begin
      samp[n] = avr_si;
      n++;
      tick();
    end
    check("load_sreg_len", 32'(n), 32'd31);
    model = '0;
    bad   = 0;
    for (int i = 0; i < 15; i++) begin
      model = {model[AW-2:0], samp[2*i]};
      if (samp[2*i] !== samp[2*i+1] || 32'(samp[2*i]) != exp_seq[i]) bad++;
    end
    check("load_bit_seq", 32'(bad), 32'd0);
    check("load_model", 32'(model), 32'h4ccf);
    check("load_tail_si", 32'(samp[30]), 32'd0);
    check("load_ready", 32'(cmd_ready), 32'd1);

    // Two READs
    for (int r = 0; r < 2; r++) begin
      avr_data_in = rd_vals[r];
      issue(OP_READ, '0, 8'h00);
      n = 0;
      while (!avr_oe_n && n < 20) begin
        n++;
        tick();
      end
      check("rd_oe_len", 32'(n), 32'd4);
      check("rd_rsp", 32'({rsp_valid, rsp_rdata}), 32'({1'b1, rd_vals[r]}));
      tick();
      check("rd_valid_pulse", 32'(rsp_valid), 32'd0);
    end
    avr_data_in = 8'h11;
    repeat (3) tick();
    check("rd_hold", 32'(rsp_rdata), 32'hbb);

    // WRITE 0xee, clock k counted from the accept edge
    issue(OP_WRITE, '0, 8'hee);
    check("wr_k1", 32'({avr_we_n, avr_data_oe, avr_data_out}), 32'({1'b1, 1'b1, 8'hee}));
    for (int k = 2; k <= 7; k++) begin
      tick();
      exp_we = !(k >= 2 && k <= 5);
      exp_oe = (k <= 6);
      check($sformatf("wr_k%0d", k), 32'({avr_we_n, avr_data_oe}), 32'({exp_we, exp_oe}));
      if (k <= 6) check($sformatf("wr_data_k%0d", k), 32'(avr_data_out), 32'hee);
    end
    check("wr_ready", 32'(cmd_ready), 32'd1);

    // INC twice back-to-back
    lo_run  = 0;
    hi_run  = 0;
    pulses  = 0;
    min_gap = 99;
    inc_mon = 1'b1;
    issue(OP_INC, '0, 8'h00);
    issue(OP_INC, '0, 8'h00);
    repeat (6) tick();
    inc_mon = 1'b0;
    check("inc_count", 32'(pulses), 32'd2);
    check("inc_len0", 32'(pulse_len[0]), 32'd2);
    check("inc_len1", 32'(pulse_len[1]), 32'd2);
    check("inc_gap_ge3", 32'(min_gap >= 3), 32'd1);

    // READ held on cmd_valid during an address shift
    check("hold_start_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD_ADDR;
    cmd_addr  = 15'h7fff;
    tick();
    cmd_op      = OP_READ;
    avr_data_in = 8'h5a;
    n   = 0;
    bad = 0;
    while (!avr_sreg_en_n && n < 64) begin
      if (!avr_oe_n) bad++;
      n++;
      tick();
    end
    check("hold_no_oe", 32'(bad), 32'd0);
    check("hold_idle", 32'({cmd_ready, avr_oe_n}), 32'(2'b11));
    tick();
    check("hold_rd_accept", 32'(avr_oe_n), 32'd0);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      n++;
      tick();
    end
    check("hold_rd_data", 32'({rsp_valid, rsp_rdata}), 32'({1'b1, 8'h5a}));

    // Reset during the third WRITE clock
    issue(OP_WRITE, '0, 8'h33);
    tick();
    tick();
    check("mid_we_low", 32'(avr_we_n), 32'd0);
    avr_reset_n = 1'b0;
    cmd_valid   = 1'b1;
    cmd_op      = OP_READ;
    tick();
    check("mid_rst_pins", 32'({avr_sreg_en_n, avr_oe_n, avr_we_n, avr_counter_n, avr_data_oe}),
          32'(5'b11110));
    check("mid_rst_data", 32'({avr_data_out, rsp_rdata}), 32'd0);
    tick();
    check("mid_rst_ignore", 32'({avr_oe_n, cmd_ready}), 32'(2'b11));
    avr_reset_n = 1'b1;
    cmd_valid   = 1'b0;
    tick();
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);

    check("invariants", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
